// File: rtl/dcache_access_unit_pkg.sv
// Shared types for the MEM-stage data cache access unit: RV32I load/store
// funct3 encodings, the access FSM states and the store byte-mask bases.
package rv32i_types;
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_t;
endpackage

package dcache_types;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    HOLD = 2'b10
  } mem_state_t;

  localparam logic [3:0] MBE_B = 4'b0001;
  localparam logic [3:0] MBE_H = 4'b0011;
  localparam logic [3:0] MBE_W = 4'b1111;
endpackage

// File: rtl/dcache_access_unit_load_align.sv
// Extracts the addressed byte/halfword/word from a dcache read word and
// sign- or zero-extends it for writeback.
module dcache_load_align
  import rv32i_types::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] load_data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  always_comb begin
    case (offset_i)
      2'b00:   byte_s = rdata_i[7:0];
      2'b01:   byte_s = rdata_i[15:8];
      2'b10:   byte_s = rdata_i[23:16];
      default: byte_s = rdata_i[31:24];
    endcase
    half_s = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (load_funct3_t'(funct3_i))
      LB:      load_data_o = {{24{byte_s[7]}}, byte_s};
      LBU:     load_data_o = {24'h000000, byte_s};
      LH:      load_data_o = {{16{half_s[15]}}, half_s};
      LHU:     load_data_o = {16'h0000, half_s};
      default: load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/dcache_access_unit.sv
// MEM-stage dcache access unit: issues requests, stalls until response and
// holds completed results. DCACHE_MISALIGN_TRAP_EN adds the misalign output.
module dcache_access_unit
  import rv32i_types::*;
  import dcache_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              flush,
  input  logic              stall_in,
  input  logic              dcache_resp,
  input  logic [DATA_W-1:0] dcache_rdata,
  output logic              dcache_read,
  output logic              dcache_write,
  output logic [ADDR_W-1:0] dcache_addr,
  output logic [3:0]        dcache_mbe,
  output logic [DATA_W-1:0] dcache_wdata,
  output logic              mem_stall,
  output logic [DATA_W-1:0] load_data,
`ifdef DCACHE_MISALIGN_TRAP_EN
  output logic              misalign,
`endif
  output logic              done
);

  mem_state_t        state_q;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              killed_q;

  logic              active_s, op_s, is_load_s, kill_s, misalign_s;
  logic              issue_s, done_s, stall_s, mis_s;
  logic [1:0]        off_s, eff_off_s;
  logic [3:0]        st_mbe_s;
  logic [DATA_W-1:0] st_wdata_s, align_s, ld_s;

  assign active_s  = req_valid & (req_read | req_write);
  assign op_s      = active_s & ~flush;
  assign is_load_s = req_read & ~req_write;
  assign off_s     = req_addr[1:0];
  assign kill_s    = killed_q | flush;

  // Halfword/word accesses only ever use the aligned part of the offset
  always_comb begin
    case (req_funct3[1:0])
      2'b00:   eff_off_s = off_s;
      2'b01:   eff_off_s = {off_s[1], 1'b0};
      default: eff_off_s = 2'b00;
    endcase
  end

`ifdef DCACHE_MISALIGN_TRAP_EN
  always_comb begin
    case (req_funct3[1:0])
      2'b01:   misalign_s = off_s[0];
      2'b10:   misalign_s = (off_s != 2'b00);
      default: misalign_s = 1'b0;
    endcase
  end
`else
  assign misalign_s = 1'b0;
`endif

  always_comb begin
    case (store_funct3_t'(req_funct3))
      SB: begin
        st_mbe_s   = MBE_B << eff_off_s;
        st_wdata_s = {4{req_wdata[7:0]}};
      end
      SH: begin
        st_mbe_s   = MBE_H << eff_off_s;
        st_wdata_s = {2{req_wdata[15:0]}};
      end
      default: begin
        st_mbe_s   = MBE_W;
        st_wdata_s = req_wdata;
      end
    endcase
  end

  dcache_load_align u_align (
    .rdata_i    (dcache_rdata),
    .offset_i   (eff_off_s),
    .funct3_i   (req_funct3),
    .load_data_o(align_s)
  );

  assign hold_d = is_load_s ? align_s : '0;

  always_comb begin
    issue_s = 1'b0;
    done_s  = 1'b0;
    stall_s = 1'b0;
    mis_s   = 1'b0;
    ld_s    = '0;
    case (state_q)
      IDLE: begin
        if (op_s && misalign_s) begin
          done_s = 1'b1;
          mis_s  = 1'b1;
        end else if (op_s) begin
          issue_s = 1'b1;
          done_s  = dcache_resp;
          stall_s = ~dcache_resp;
          ld_s    = dcache_resp ? hold_d : '0;
        end else begin
          done_s = 1'b0;
        end
      end
      // A flushed access keeps its request up; the cache cannot abort it
      WAIT: begin
        issue_s = active_s;
        stall_s = ~dcache_resp;
        done_s  = dcache_resp & ~kill_s;
        ld_s    = (dcache_resp && !kill_s) ? hold_d : '0;
      end
      HOLD: begin
        done_s = 1'b1;
        ld_s   = hold_q;
      end
      default: begin
        done_s = 1'b0;
      end
    endcase
    if (!rst) begin
      issue_s = 1'b0;
      done_s  = 1'b0;
      stall_s = 1'b0;
      mis_s   = 1'b0;
      ld_s    = '0;
    end else begin
      mis_s = mis_s;
    end
  end

  assign dcache_read  = issue_s & is_load_s;
  assign dcache_write = issue_s & req_write;
  assign dcache_addr  = issue_s ? {req_addr[ADDR_W-1:2], 2'b00} : '0;
  assign dcache_mbe   = issue_s ? (req_write ? st_mbe_s : MBE_W) : 4'b0000;
  assign dcache_wdata = (issue_s && req_write) ? st_wdata_s : '0;
  assign mem_stall    = stall_s;
  assign load_data    = ld_s;
  assign done         = done_s;
`ifdef DCACHE_MISALIGN_TRAP_EN
  assign misalign     = mis_s;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      killed_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          killed_q <= 1'b0;
          if (op_s && !misalign_s) begin
            if (!dcache_resp) begin
              state_q <= WAIT;
            end else if (stall_in) begin
              state_q <= HOLD;
              hold_q  <= hold_d;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        WAIT: begin
          if (dcache_resp) begin
            killed_q <= 1'b0;
            if (!kill_s && stall_in) begin
              state_q <= HOLD;
              hold_q  <= hold_d;
            end else begin
              state_q <= IDLE;
            end
          end else if (flush) begin
            killed_q <= 1'b1;
          end
        end
        HOLD: begin
          if (!stall_in) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_access_unit.sv
// Self-checking bench for dcache_access_unit with a scoreboard of expected
// load results; covers the misalign trap when DCACHE_MISALIGN_TRAP_EN is set.
module tb_dcache_access_unit;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_read, req_write, flush, stall_in, dcache_resp;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, dcache_rdata;
  logic        dcache_read, dcache_write, mem_stall, done;
  logic [31:0] dcache_addr, dcache_wdata, load_data;
  logic [3:0]  dcache_mbe;
`ifdef DCACHE_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  int          rd_cnt, wr_cnt, stall_cnt;
  logic        done_obs;
  logic [31:0] ld_obs, addr_obs, wdata_obs;
  logic [3:0]  mbe_obs;

  always #5 clk = ~clk;

  dcache_access_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_read(req_read),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .flush(flush), .stall_in(stall_in),
    .dcache_resp(dcache_resp), .dcache_rdata(dcache_rdata),
    .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_addr(dcache_addr), .dcache_mbe(dcache_mbe),
    .dcache_wdata(dcache_wdata), .mem_stall(mem_stall), .load_data(load_data),
`ifdef DCACHE_MISALIGN_TRAP_EN
    .misalign(misalign),
`endif
    .done(done)
  );

  task automatic set_req(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1; req_read = rd; req_write = wr;
    req_funct3 = f3; req_addr = addr; req_wdata = wd;
  endtask

  task automatic idle_cycle();
    req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
    dcache_resp = 1'b0; flush = 1'b0; stall_in = 1'b0;
    @(posedge clk); #1;
  endtask

  // Plays the dcache: response after lat cycles, records what the DUT did
  task automatic run_access(input int lat, input logic [31:0] rd, input logic st);
    rd_cnt = 0; wr_cnt = 0; stall_cnt = 0;
    for (int c = 0; c <= lat; c++) begin
      dcache_resp  = (c == lat);
      dcache_rdata = (c == lat) ? rd : 32'h0;
      if (c == lat) stall_in = st;
      @(negedge clk);
      if (dcache_read)  rd_cnt++;
      if (dcache_write) wr_cnt++;
      if (mem_stall)    stall_cnt++;
      if (c == 0) begin
        addr_obs = dcache_addr; mbe_obs = dcache_mbe; wdata_obs = dcache_wdata;
      end
      if (c == lat) begin
        done_obs = done; ld_obs = load_data;
      end
      @(posedge clk); #1;
    end
    dcache_resp = 1'b0;
    dcache_rdata = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_req(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    flush = 1'b0; stall_in = 1'b0; dcache_resp = 1'b1; dcache_rdata = 32'h1234;
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if ({dcache_read, dcache_write, mem_stall, done} !== 4'b0000 ||
        dcache_addr !== 32'h0 || dcache_mbe !== 4'h0 || dcache_wdata !== 32'h0 ||
        load_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: rd=%b wr=%b stall=%b done=%b addr=%h mbe=%b ld=%h, want all 0",
               dcache_read, dcache_write, mem_stall, done, dcache_addr, dcache_mbe, load_data);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    idle_cycle();
  endtask

  task automatic test_lw_wait();
    set_req(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    exp_q.push_back(32'hDEADBEEF);
    run_access(3, 32'hDEADBEEF, 1'b0);
    exp_v = exp_q.pop_front();
    tests++;
    if (rd_cnt != 4 || stall_cnt != 3 || wr_cnt != 0) begin
      fails++;
      $display("FAIL lw_wait_cycles: read=%0d stall=%0d write=%0d, want 4 3 0", rd_cnt, stall_cnt, wr_cnt);
    end
    tests++;
    if (done_obs !== 1'b1 || ld_obs !== exp_v) begin
      fails++;
      $display("FAIL lw_wait_result: done=%b ld=%h, want 1 %h", done_obs, ld_obs, exp_v);
    end
    tests++;
    if (addr_obs !== 32'h100 || mbe_obs !== 4'b1111) begin
      fails++;
      $display("FAIL lw_addr_mbe: addr=%h mbe=%b, want 00000100 1111", addr_obs, mbe_obs);
    end
    idle_cycle();
  endtask

  task automatic test_stores();
    logic [2:0]  f3 [3] = '{3'b000, 3'b001, 3'b010};
    logic [31:0] ad [3] = '{32'h203, 32'h202, 32'h208};
    logic [31:0] wd [3] = '{32'h000000A5, 32'h1234ABCD, 32'hCAFEF00D};
    logic [31:0] ea [3] = '{32'h200, 32'h200, 32'h208};
    logic [3:0]  em [3] = '{4'b1000, 4'b1100, 4'b1111};
    logic [31:0] ew [3] = '{32'hA5A5A5A5, 32'hABCDABCD, 32'hCAFEF00D};
    for (int i = 0; i < 3; i++) begin
      set_req(1'b0, 1'b1, f3[i], ad[i], wd[i]);
      run_access(2, 32'h0, 1'b0);
      tests++;
      if (addr_obs !== ea[i] || mbe_obs !== em[i] || wdata_obs !== ew[i]) begin
        fails++;
        $display("FAIL store_%0d_lanes: addr=%h mbe=%b wdata=%h, want %h %b %h",
                 i, addr_obs, mbe_obs, wdata_obs, ea[i], em[i], ew[i]);
      end
      tests++;
      if (wr_cnt != 3 || rd_cnt != 0 || done_obs !== 1'b1) begin
        fails++;
        $display("FAIL store_%0d_handshake: write=%0d read=%0d done=%b, want 3 0 1",
                 i, wr_cnt, rd_cnt, done_obs);
      end
      idle_cycle();
    end
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3 [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b010};
    logic [31:0] ad [6] = '{32'h102, 32'h102, 32'h100, 32'h102, 32'h101, 32'h104};
    logic [31:0] rd [6] = '{32'h0080FF00, 32'h0080FF00, 32'h00008001,
                            32'h80010000, 32'h00007F00, 32'h12345678};
    logic [31:0] ex [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001,
                            32'h00008001, 32'h0000007F, 32'h12345678};
    for (int i = 0; i < 6; i++) begin
      set_req(1'b1, 1'b0, f3[i], ad[i], 32'h0);
      exp_q.push_back(ex[i]);
      run_access(0, rd[i], 1'b0);
      exp_v = exp_q.pop_front();
      tests++;
      if (done_obs !== 1'b1 || ld_obs !== exp_v || stall_cnt != 0) begin
        fails++;
        $display("FAIL load_%0d_extend: done=%b ld=%h stall=%0d, want 1 %h 0",
                 i, done_obs, ld_obs, stall_cnt, exp_v);
      end
      idle_cycle();
    end
  endtask

  task automatic test_hold();
    int hold_reads = 0;
    int bad = 0;
    set_req(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
    exp_q.push_back(32'h5A5A0F0F);
    run_access(1, 32'h5A5A0F0F, 1'b1);
    exp_v = exp_q.pop_front();
    tests++;
    if (done_obs !== 1'b1 || ld_obs !== exp_v || rd_cnt != 2) begin
      fails++;
      $display("FAIL hold_resp: done=%b ld=%h reads=%0d, want 1 %h 2", done_obs, ld_obs, rd_cnt, exp_v);
    end
    for (int h = 0; h < 4; h++) begin
      if (h == 3) stall_in = 1'b0;
      @(negedge clk);
      if (dcache_read || dcache_write) hold_reads++;
      if (done !== 1'b1 || load_data !== exp_v || mem_stall !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    tests++;
    if (hold_reads != 0 || bad != 0) begin
      fails++;
      $display("FAIL hold_stable: reissues=%0d bad_cycles=%0d, want 0 0", hold_reads, bad);
    end
    req_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || mem_stall !== 1'b0 || load_data !== 32'h0) begin
      fails++;
      $display("FAIL hold_exit: done=%b stall=%b ld=%h, want 0 0 0", done, mem_stall, load_data);
    end
    idle_cycle();
  endtask

  task automatic test_flush();
    int reads = 0;
    logic done_r = 1'b0;
    set_req(1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
    flush = 1'b1;
    @(negedge clk);
    tests++;
    if (dcache_read !== 1'b0 || mem_stall !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL flush_idle: read=%b stall=%b done=%b, want 0 0 0", dcache_read, mem_stall, done);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    for (int c = 0; c <= 3; c++) begin
      flush = (c == 1);
      dcache_resp = (c == 3);
      dcache_rdata = 32'h11112222;
      @(negedge clk);
      if (dcache_read) reads++;
      if (c == 3) done_r = done;
      @(posedge clk); #1;
    end
    dcache_resp = 1'b0; flush = 1'b0; req_valid = 1'b0;
    tests++;
    if (reads != 4 || done_r !== 1'b0) begin
      fails++;
      $display("FAIL flush_wait: reads=%0d done=%b, want 4 0", reads, done_r);
    end
    @(negedge clk);
    tests++;
    if (mem_stall !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL flush_exit: stall=%b done=%b, want 0 0", mem_stall, done);
    end
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    set_req(1'b1, 1'b0, 3'b010, 32'h500, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if ({dcache_read, dcache_write, mem_stall, done} !== 4'b0000 || load_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_mid: rd=%b wr=%b stall=%b done=%b ld=%h, want all 0",
               dcache_read, dcache_write, mem_stall, done, load_data);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (mem_stall !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_idle: stall=%b done=%b, want 0 0", mem_stall, done);
    end
    idle_cycle();
  endtask

  task automatic test_misalign();
`ifdef DCACHE_MISALIGN_TRAP_EN
    set_req(1'b1, 1'b0, 3'b010, 32'h102, 32'h0);
    @(negedge clk);
    tests++;
    if (dcache_read !== 1'b0 || misalign !== 1'b1 || done !== 1'b1 || mem_stall !== 1'b0) begin
      fails++;
      $display("FAIL misalign_lw: read=%b mis=%b done=%b stall=%b, want 0 1 1 0",
               dcache_read, misalign, done, mem_stall);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (mem_stall !== 1'b0 || done !== 1'b0 || misalign !== 1'b0) begin
      fails++;
      $display("FAIL misalign_idle: stall=%b done=%b mis=%b, want 0 0 0", mem_stall, done, misalign);
    end
`else
    set_req(1'b0, 1'b1, 3'b001, 32'h101, 32'h0000BEEF);
    run_access(0, 32'h0, 1'b0);
    tests++;
    if (addr_obs !== 32'h100 || mbe_obs !== 4'b0011 || wdata_obs !== 32'hBEEFBEEF) begin
      fails++;
      $display("FAIL forced_align_sh: addr=%h mbe=%b wdata=%h, want 00000100 0011 beefbeef",
               addr_obs, mbe_obs, wdata_obs);
    end
`endif
    idle_cycle();
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
    req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    flush = 1'b0; stall_in = 1'b0; dcache_resp = 1'b0; dcache_rdata = 32'h0;
    test_reset();
    test_lw_wait();
    test_stores();
    test_load_extend();
    test_hold();
    test_flush();
    test_reset_mid();
    test_misalign();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dcache_access_unit.md
Name: dcache_access_unit

Overview:
- MEM-stage consumer of the decoded control word: takes ctrl_t dcache_read/dcache_write, funct3, ALU address and rs2 data; drives the dcache request/response handshake.
- Generates byte masks and aligned store data, and extracts/extends load data for writeback.
- Stalls the pipeline while a request is outstanding.
- Holds a completed result while another unit stalls, so no access is ever re-issued.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be 32 (RV32I), other values unsupported.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- req_valid  in  1  EX/MEM register holds a valid instruction.
- req_read  in  1  ctrl_t.dcache_read.
- req_write  in  1  ctrl_t.dcache_write.
- req_funct3  in  3  instr_t.funct3 (load_funct3_t / store_funct3_t encoding).
- req_addr  in  32  ALU result (byte address).
- req_wdata  in  32  rs2 value.
- flush  in  1  kill instruction currently in MEM.
- stall_in  in  1  stall from other units (icache miss etc.).
- dcache_resp  in  1  dcache completion, one-cycle pulse.
- dcache_rdata  in  32  dcache read word.
- dcache_read  out  1  read request.
- dcache_write  out  1  write request.
- dcache_addr  out  32  req_addr with bits [1:0] cleared.
- dcache_mbe  out  4  byte enables.
- dcache_wdata  out  32  lane-shifted store data.
- mem_stall  out  1  MEM cannot advance.
- load_data  out  32  aligned, extended load result.
- done  out  1  access completed this cycle / held complete.

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE, hold register cleared; all outputs 0. Reset mid-access abandons the transaction (dcache is reset concurrently).
- States: IDLE, WAIT, HOLD.
- op = req_valid & (req_read | req_write) & ~flush.
- Request outputs:
  - Combinational; dcache_read = op & req_read, dcache_write = op & req_write.
  - Asserted in IDLE and WAIT, 0 in HOLD.
  - Inputs are held stable by mem_stall, so the request stays asserted until dcache_resp.
- IDLE:
  - op & ~dcache_resp -> WAIT.
  - op & dcache_resp (zero-wait hit) -> complete this cycle.
  - No op -> stay; mem_stall=0, done=0.
- WAIT: mem_stall=1 until dcache_resp.
- On resp (IDLE or WAIT):
  - stall_in=1 -> capture load_data into hold register -> HOLD.
  - Otherwise done=1, mem_stall=0 -> IDLE.
- HOLD:
  - No request; mem_stall=0; done=1; load_data from hold register.
  - stall_in=0 -> IDLE (pipeline advances that cycle).
- Flush:
  - In IDLE: suppresses the request.
  - In WAIT: the cache transaction is not aborted. Flag the access killed, finish on resp with done=0, then -> IDLE. Stores still complete.
- Store mask/data, o = req_addr[1:0]:
  - sb: mbe = 4'b0001<<o; wdata = rs2[7:0] replicated to all 4 lanes.
  - sh: mbe = 4'b0011<<o (o in {0,2}); wdata = rs2[15:0] replicated.
  - sw: mbe = 4'b1111; wdata = rs2.
- Loads: dcache_mbe=4'b1111.
  - lb/lbu: byte at lane o, sign-/zero-extended.
  - lh/lhu: halfword at o, extended.
  - lw: word.
- load_data is combinational from dcache_rdata on the resp cycle, from the hold register in HOLD, and 0 otherwise.
- Both read and write set: treated as write; does not occur from decode.

Optional Feature:
- Macro DCACHE_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign (1 bit). Misaligned = sh/lh/lhu with o[0]=1, or sw/lw with o!=0.
  - When misaligned: no dcache request; misalign=1 and done=1 in the same cycle; state stays IDLE; mem_stall=0.
- Undefined: the low offset bits are ignored for halfword/word access (forced alignment), and the port is absent.

Decomposition:
- Package dcache_types: mem_state_t enum {IDLE, WAIT, HOLD}; store mask base constants (MBE_B=4'b0001, MBE_H=4'b0011, MBE_W=4'b1111).
- Reuse load_funct3_t / store_funct3_t from rv32i_types.
- Sub-module: dcache_load_align, combinational (rdata, offset, funct3) -> load_data; the same instance also feeds the hold register.

Test Plan:
- lw addr 0x100, resp after 3 cycles, rdata 0xDEADBEEF -> read asserted 4 cycles, mem_stall 3 cycles, done=1 with load_data=0xDEADBEEF on resp cycle.
- sb addr 0x203, rs2=0x000000A5 -> dcache_addr=0x200, mbe=4'b1000, wdata=0xA5A5A5A5, write until resp.
- lb addr 0x102, rdata 0x0080FF00 -> load_data=0xFFFFFF80; lbu same -> 0x00000080; lh addr 0x100, rdata 0x00008001 -> 0xFFFF8001.
- lw resp while stall_in=1 for 4 cycles -> exactly one read request, HOLD for 4 cycles with done=1, stable load_data, no re-issue; IDLE after stall_in drops.
- flush asserted during WAIT -> request held until resp, done=0 on resp, back to IDLE; rst=0 during WAIT -> next cycle all outputs 0, state IDLE.
- With DCACHE_MISALIGN_TRAP_EN: lw addr 0x102 -> no request, misalign=1, done=1 same cycle.
